// File: rtl/riscv_control_unit_pkg.sv
// Shared encodings for the RV32I control unit: opcodes, funct3 values,
// ALU operation codes and the datapath select encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRA = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU   = 2'b00,
        RES_MEM   = 2'b01,
        RES_PC4   = 2'b10,
        RES_UPIMM = 2'b11
    } result_src_e;

    // Instruction class as seen by the ALU decoder.
    typedef enum logic [2:0] {
        CLS_ADD    = 3'd0,
        CLS_MEM    = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_ITYPE  = 3'd3,
        CLS_BRANCH = 3'd4
    } alu_class_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        logic        jump;
    } main_ctrl_t;

endpackage

// File: rtl/riscv_control_unit_if.sv
// Instruction fields in, datapath controls out. The decoder uses the slave
// modport; whoever drives the instruction uses master.
interface riscv_control_unit_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       PCSrc;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic       IllegalSticky;

    modport master (
        output op, funct3, funct7, Zero,
        input  RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, PCSrc,
               ALUControl, Illegal, IllegalSticky
    );

    modport slave (
        input  op, funct3, funct7, Zero,
        output RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, PCSrc,
               ALUControl, Illegal, IllegalSticky
    );

endinterface

// File: rtl/riscv_alu_decoder.sv
// Maps instruction class, funct3 and instr[30] to an ALU operation, and flags
// funct3/funct7 combinations that the class does not support.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_class_e i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7,
    output alu_ctrl_e  o_alu_ctrl,
    output logic       o_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through this block can leave a value held, which would infer a latch.
        o_alu_ctrl = ALU_ADD;
        o_illegal  = 1'b0;

        case (i_class)
            CLS_MEM: begin
                o_illegal = (i_funct3 != F3_WORD);
            end
            CLS_RTYPE, CLS_ITYPE: begin
                case (i_funct3)
                    // instr[30] selects sub only for register-register adds;
                    // in addi it is part of the immediate.
                    F3_ADD:  o_alu_ctrl = (i_class == CLS_RTYPE && i_funct7) ? ALU_SUB : ALU_ADD;
                    F3_AND:  o_alu_ctrl = ALU_AND;
                    F3_OR:   o_alu_ctrl = ALU_OR;
                    F3_XOR:  o_alu_ctrl = ALU_XOR;
                    F3_SLT:  o_alu_ctrl = ALU_SLT;
                    F3_SLL:  o_alu_ctrl = ALU_SLL;
                    F3_SR: begin
                        if (i_funct7) o_alu_ctrl = ALU_SRA;
                        else          o_illegal  = 1'b1;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            CLS_BRANCH: begin
                case (i_funct3)
                    F3_BEQ, F3_BNE: o_alu_ctrl = ALU_SUB;
                    F3_BLT, F3_BGE: o_alu_ctrl = ALU_SLT;
                    default:        o_illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_control_unit.sv
// Single-cycle RV32I control unit: main decoder, branch resolution and a
// sticky record of any illegal instruction seen since reset.
module riscv_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    riscv_control_unit_if.slave   ctrl
);

    main_ctrl_t w_main;
    alu_class_e w_class;
    logic       w_op_known;
    alu_ctrl_e  w_alu_ctrl;
    logic       w_alu_illegal;
    logic       w_taken;
    logic       w_illegal;
    logic       w_valid;
    logic       r_illegal_sticky;

    always_comb begin
        w_main     = '0;
        w_class    = CLS_ADD;
        w_op_known = 1'b1;

        case (ctrl.op)
            OP_RTYPE: begin
                w_main.reg_write = 1'b1;
                w_class          = CLS_RTYPE;
            end
            OP_ITYPE: begin
                w_main.reg_write = 1'b1;
                w_main.alu_src   = 1'b1;
                w_class          = CLS_ITYPE;
            end
            OP_LOAD: begin
                w_main.reg_write  = 1'b1;
                w_main.alu_src    = 1'b1;
                w_main.result_src = RES_MEM;
                w_class           = CLS_MEM;
            end
            OP_STORE: begin
                w_main.imm_src   = IMM_S;
                w_main.alu_src   = 1'b1;
                w_main.mem_write = 1'b1;
                w_class          = CLS_MEM;
            end
            OP_BRANCH: begin
                w_main.imm_src = IMM_B;
                w_main.branch  = 1'b1;
                w_class        = CLS_BRANCH;
            end
            OP_JAL: begin
                w_main.reg_write  = 1'b1;
                w_main.imm_src    = IMM_J;
                w_main.result_src = RES_PC4;
                w_main.jump       = 1'b1;
            end
            OP_LUI: begin
                w_main.reg_write  = 1'b1;
                w_main.result_src = RES_UPIMM;
            end
            default: w_op_known = 1'b0;
        endcase
    end

    riscv_alu_decoder u_alu_decoder (
        .i_class    (w_class),
        .i_funct3   (ctrl.funct3),
        .i_funct7   (ctrl.funct7),
        .o_alu_ctrl (w_alu_ctrl),
        .o_illegal  (w_alu_illegal)
    );

    // beq/bge take the branch on Zero (equal / slt result 0); bne/blt on ~Zero.
    always_comb begin
        case (ctrl.funct3)
            F3_BEQ, F3_BGE: w_taken = ctrl.Zero;
            F3_BNE, F3_BLT: w_taken = ~ctrl.Zero;
            default:        w_taken = 1'b0;
        endcase
    end

    assign w_illegal = ~rst & (~w_op_known | w_alu_illegal);
    assign w_valid   = ~rst & ~w_illegal;

    // Reset and illegal instructions both drive every control to zero.
    always_comb begin
        ctrl.RegWrite   = 1'b0;
        ctrl.ImmSrc     = IMM_I;
        ctrl.ALUSrc     = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.ResultSrc  = RES_ALU;
        ctrl.PCSrc      = 1'b0;
        ctrl.ALUControl = ALU_ADD;
        if (w_valid) begin
            ctrl.RegWrite   = w_main.reg_write;
            ctrl.ImmSrc     = w_main.imm_src;
            ctrl.ALUSrc     = w_main.alu_src;
            ctrl.MemWrite   = w_main.mem_write;
            ctrl.ResultSrc  = w_main.result_src;
            ctrl.PCSrc      = w_main.jump | (w_main.branch & w_taken);
            ctrl.ALUControl = w_alu_ctrl;
        end
    end

    assign ctrl.Illegal       = w_illegal;
    assign ctrl.IllegalSticky = r_illegal_sticky;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its inputs from before the edge.
        if (rst)            r_illegal_sticky <= 1'b0;
        else if (w_illegal) r_illegal_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_riscv_control_unit.sv
// Directed-vector bench for riscv_control_unit with hand-computed expectations.
module tb_riscv_control_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    riscv_control_unit_if bus ();

    riscv_control_unit dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Packed as {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, PCSrc, ALUControl, Illegal}.
    function automatic logic [11:0] outs();
        return {bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.MemWrite, bus.ResultSrc,
                bus.PCSrc, bus.ALUControl, bus.Illegal};
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        @(negedge clk);
        bus.op     = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.Zero   = z;
        #1;
    endtask

    task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [11:0] exp);
        drive(op, f3, f7, z);
        check(tag, {4'b0, outs()}, {4'b0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with jal on the bus: controls suppressed, sticky cleared at the edge.
        rst = 1'b1;
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        check("rst_regwrite", {15'b0, bus.RegWrite}, 16'd0);
        check("rst_pcsrc",    {15'b0, bus.PCSrc},    16'd0);
        check("rst_illegal",  {15'b0, bus.Illegal},  16'd0);
        @(posedge clk); #1;
        check("rst_sticky",   {15'b0, bus.IllegalSticky}, 16'd0);
        rst = 1'b0;

        //                                              RW ImS AS MW RS PC ALU Il
        vec("add",       7'b0110011, 3'b000, 1'b0, 1'b0, 12'b1_00_0_0_00_0_000_0);
        vec("sub",       7'b0110011, 3'b000, 1'b1, 1'b0, 12'b1_00_0_0_00_0_001_0);
        vec("and",       7'b0110011, 3'b111, 1'b0, 1'b0, 12'b1_00_0_0_00_0_010_0);
        vec("or",        7'b0110011, 3'b110, 1'b0, 1'b0, 12'b1_00_0_0_00_0_011_0);
        vec("sra",       7'b0110011, 3'b101, 1'b1, 1'b0, 12'b1_00_0_0_00_0_111_0);
        vec("addi_f7",   7'b0010011, 3'b000, 1'b1, 1'b0, 12'b1_00_1_0_00_0_000_0);
        vec("slti",      7'b0010011, 3'b010, 1'b0, 1'b0, 12'b1_00_1_0_00_0_101_0);
        vec("srai",      7'b0010011, 3'b101, 1'b1, 1'b0, 12'b1_00_1_0_00_0_111_0);
        vec("lw",        7'b0000011, 3'b010, 1'b0, 1'b0, 12'b1_00_1_0_01_0_000_0);
        vec("sw",        7'b0100011, 3'b010, 1'b0, 1'b0, 12'b0_01_1_1_00_0_000_0);
        vec("beq_z0",    7'b1100011, 3'b000, 1'b0, 1'b0, 12'b0_10_0_0_00_0_001_0);
        vec("beq_z1",    7'b1100011, 3'b000, 1'b0, 1'b1, 12'b0_10_0_0_00_1_001_0);
        vec("bne_z1",    7'b1100011, 3'b001, 1'b0, 1'b1, 12'b0_10_0_0_00_0_001_0);
        vec("blt_z0",    7'b1100011, 3'b100, 1'b0, 1'b0, 12'b0_10_0_0_00_1_101_0);
        vec("bge_z1",    7'b1100011, 3'b101, 1'b0, 1'b1, 12'b0_10_0_0_00_1_101_0);
        vec("jal",       7'b1101111, 3'b000, 1'b0, 1'b0, 12'b1_11_0_0_10_1_000_0);
        vec("jal_zero",  7'b1101111, 3'b101, 1'b1, 1'b1, 12'b1_11_0_0_10_1_000_0);
        vec("lui",       7'b0110111, 3'b000, 1'b0, 1'b1, 12'b1_00_0_0_11_0_000_0);
        @(posedge clk); #1;
        check("sticky_clean", {15'b0, bus.IllegalSticky}, 16'd0);

        vec("srli",      7'b0010011, 3'b101, 1'b0, 1'b0, 12'b0_00_0_0_00_0_000_1);
        @(posedge clk); #1;
        check("sticky_set", {15'b0, bus.IllegalSticky}, 16'd1);

        vec("bad_op",    7'b0000000, 3'b000, 1'b0, 1'b0, 12'b0_00_0_0_00_0_000_1);
        vec("lw_f3",     7'b0000011, 3'b000, 1'b0, 1'b0, 12'b0_00_0_0_00_0_000_1);
        vec("sw_f3",     7'b0100011, 3'b011, 1'b0, 1'b0, 12'b0_00_0_0_00_0_000_1);
        vec("r_f3_011",  7'b0110011, 3'b011, 1'b0, 1'b0, 12'b0_00_0_0_00_0_000_1);
        vec("br_f3_010", 7'b1100011, 3'b010, 1'b0, 1'b1, 12'b0_00_0_0_00_0_000_1);

        vec("add_after", 7'b0110011, 3'b000, 1'b0, 1'b0, 12'b1_00_0_0_00_0_000_0);
        @(posedge clk); #1;
        check("sticky_hold", {15'b0, bus.IllegalSticky}, 16'd1);

        // Reset while an illegal opcode is present: Illegal suppressed, sticky cleared.
        rst = 1'b1;
        drive(7'b1111111, 3'b000, 1'b0, 1'b0);
        check("rst2_illegal", {15'b0, bus.Illegal}, 16'd0);
        check("rst2_sticky_pre", {15'b0, bus.IllegalSticky}, 16'd1);
        @(posedge clk); #1;
        check("rst2_sticky", {15'b0, bus.IllegalSticky}, 16'd0);
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        check("rst2_jal_regw",  {15'b0, bus.RegWrite}, 16'd0);
        check("rst2_jal_pcsrc", {15'b0, bus.PCSrc},    16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_jal", {4'b0, outs()}, {4'b0, 12'b1_11_0_0_10_1_000_0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_control_unit.md
Name: riscv_control_unit

Overview:
- Instruction decoder and branch resolver for the single-cycle RV32I core.
- Takes the opcode, funct3 and instr[30] (funct7 bit 5) from the current instruction, plus the ALU Zero flag.
- Drives the datapath selects, write enables, ALU operation and PC source.
- Decode is purely combinational; the only state is a sticky illegal-instruction flag.

Parameters:
- none

Ports:
- clk  in  1  core clock; the only sequential element is IllegalSticky
- rst  in  1  synchronous, active-high reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  1  instr[30]
- Zero  in  1  ALU result == 0
- RegWrite  out  1  register-file write enable
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUSrc  out  1  ALU operand B: 0 = rs2, 1 = immediate
- MemWrite  out  1  data-memory write enable
- ResultSrc  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 upper immediate {instr[31:12],12'b0}
- PCSrc  out  1  1 = PC <- PC + immediate
- ALUControl  out  3  ALU operation code (see Behaviour)
- Illegal  out  1  current instruction is unsupported (combinational)
- IllegalSticky  out  1  registered, sticky record of any illegal instruction

Behaviour:
- ALUControl codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 sra.
- Outputs listed per opcode in the order RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, PCSrc.
- R-type, op 0110011: 1, 00, 0, 0, 00, PCSrc 0.
  - ALUControl from funct3: 000 gives add if funct7=0 and sub if funct7=1; 111 and; 110 or; 100 xor; 010 slt; 001 sll; 101 sra only if funct7=1.
  - Any other funct3/funct7 combination is illegal.
- I-type ALU, op 0010011: 1, 00, 1, 0, 00, PCSrc 0.
  - funct7 is ignored for addi (funct3 000), so addi never becomes sub.
  - andi/ori/xori/slti/slli decode as in R-type.
  - srai needs funct3 101 with funct7=1; funct3 101 with funct7=0 (srli) is illegal.
- lw, op 0000011 with funct3 010: 1, 00, 1, 0, 01, PCSrc 0, ALUControl add. Other funct3 values are illegal.
- sw, op 0100011 with funct3 010: 0, 01, 1, 1, 00, PCSrc 0, ALUControl add. Other funct3 values are illegal.
- Branch, op 1100011: 0, 10, 0, 0, 00.
  - beq (000): ALUControl sub, PCSrc = Zero.
  - bne (001): ALUControl sub, PCSrc = ~Zero.
  - blt (100): ALUControl slt, PCSrc = ~Zero.
  - bge (101): ALUControl slt, PCSrc = Zero.
  - Other funct3 values are illegal.
- jal, op 1101111: 1, 11, 0, 0, 10, PCSrc 1, ALUControl add.
- lui, op 0110111: 1, 00, 0, 0, 11, PCSrc 0, ALUControl add.
- Illegal or unknown opcode: all outputs are 0 and Illegal = 1.
- All of the above is combinational; outputs are valid in the same cycle as the inputs.
- While rst=1:
  - RegWrite, MemWrite and PCSrc are forced to 0 combinationally.
  - Illegal reads 0.
  - IllegalSticky clears to 0 at the next rising clk edge.
- When rst=0, IllegalSticky is set at a rising edge if Illegal=1, and holds until the next reset.
- Reset values of every output: RegWrite 0, ImmSrc 00, ALUSrc 0, MemWrite 0, ResultSrc 00, PCSrc 0, ALUControl 000, Illegal 0, IllegalSticky 0.
- Zero affects only PCSrc, and only for branches.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants;
  - ALUControl, ImmSrc and ResultSrc encodings;
  - funct3 constants.
- One sub-module, riscv_alu_decoder, maps (op class, funct3, funct7) to ALUControl plus a per-class illegal flag.
- The main decoder, branch logic and the sticky register stay in the top module.

Test Plan:
- add (op 0110011, f3 000, f7 0) gives RegW 1, ImmSrc 00, ALUSrc 0, MemW 0, ResultSrc 00, ALUControl 000, PCSrc 0; with f7 1 the same outputs but ALUControl 001. and (f3 111) gives ALUControl 010.
- addi with f7 1 gives ALUControl 000 and ALUSrc 1. srai (0010011/101/1) gives 111. srli (f7 0) gives Illegal 1, all outputs 0, and IllegalSticky 1 after the edge.
- lw (0000011/010) gives RegW 1, ALUSrc 1, ResultSrc 01. sw (0100011/010) gives RegW 0, ImmSrc 01, MemW 1.
- beq with Zero 0 gives PCSrc 0; with Zero 1, PCSrc 1, ImmSrc 10, ALUControl 001. bge with Zero 1 gives ALUControl 101 and PCSrc 1; bne with Zero 1 gives PCSrc 0.
- jal gives RegW 1, ImmSrc 11, ResultSrc 10, PCSrc 1. lui gives RegW 1, ResultSrc 11, PCSrc 0.
- Drive rst=1 with jal: RegW 0, PCSrc 0, Illegal 0, and IllegalSticky cleared after one edge.
